// File: rtl/pakin_pkg.sv
// Shared types and helpers for the pakin packet-to-message reassembler.
package pakin_pkg;

    // Input channel: waiting for a packet, or holding rcv0_ack high.
    typedef enum logic [0:0] {
        InWait,
        InAck
    } in_st_e;

    // Output channel: idle, or presenting a message with snd0_req high.
    typedef enum logic [0:0] {
        OutIdle,
        OutReq
    } out_st_e;

    // Working width for the redundancy sum; all message fields must fit.
    localparam int unsigned RedunSumW = 64;

    // Message vector width {src, dst, dat, red}.
    function automatic int unsigned msg_size(input int unsigned asz, input int unsigned dsz,
                                             input int unsigned rsz);
        return 2 * asz + dsz + rsz;
    endfunction

    // Packets per message; the last packet is always at least partly padding.
    function automatic int unsigned tot_pks(input int unsigned msz, input int unsigned psz);
        return msz / psz + 1;
    endfunction

    // Redundancy sum over zero-extended fields; the caller truncates to RSZ.
    function automatic logic [RedunSumW-1:0] redun_sum(input logic [RedunSumW-1:0] src,
                                                       input logic [RedunSumW-1:0] dst,
                                                       input logic [RedunSumW-1:0] dat);
        return src + dst + dat;
    endfunction

endpackage

// File: rtl/pakin_fifo.sv
// Message FIFO for pakin: Depth entries of Width bits, power-of-two depth.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module pakin_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IdxW = $clog2(Depth);

    logic [IdxW:0]      head_q, head_d;
    logic [IdxW:0]      tail_q, tail_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push;
    logic               do_pop;

    // Flags, accepted operations and next pointers.
    always_comb begin
        empty_o = (head_q == tail_q);
        full_o  = (head_q[IdxW] != tail_q[IdxW]) &&
                  (head_q[IdxW-1:0] == tail_q[IdxW-1:0]);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        head_d  = head_q;
        tail_d  = tail_q;
        if (do_push) begin
            head_d = head_q + 1'b1;
        end
        if (do_pop) begin
            tail_d = tail_q + 1'b1;
        end
        rdata_o = mem_q[tail_q[IdxW-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[head_q[IdxW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pakin.sv
// pakin: reassembles fixed-width packets from a four-phase req/ack packet
// channel into {src, dst, dat, red} messages, buffers them in pakin_fifo and
// presents them on a four-phase message channel.
// Optional feature macro: NS_PAKIN_REDUN_CHECK_EN adds the redundancy check
// and the sticky err output.
module pakin
    import pakin_pkg::*;
#(
    parameter int unsigned PSZ         = 4,
    parameter int unsigned FSZ         = 2,
    parameter int unsigned ASZ         = 6,
    parameter int unsigned DSZ         = 4,
    parameter int unsigned RSZ         = 4,
    parameter int unsigned RCV_REQ_CKS = 2,
    parameter int unsigned SND_ACK_CKS = 2
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic [PSZ:0]   rcv0_pakio,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           snd0_req,
    input  logic           snd0_ack
`ifdef NS_PAKIN_REDUN_CHECK_EN
    ,
    output logic           err
`endif
);

    localparam int unsigned MSZ     = msg_size(ASZ, DSZ, RSZ);
    localparam int unsigned TOT_PKS = tot_pks(MSZ, PSZ);
    localparam int unsigned PW      = TOT_PKS * PSZ;
    localparam int unsigned SHW     = PW - PSZ;
    localparam int unsigned IDXW    = $clog2(TOT_PKS);
    localparam int unsigned RCW     = $clog2(RCV_REQ_CKS + 1);
    localparam int unsigned ACW     = $clog2(SND_ACK_CKS + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOT_PKS - 1);

    // ------------------------------------------------------------------
    // Init flag
    // ------------------------------------------------------------------
    logic ready_q;

    // The first cycle out of reset is the init cycle; ready rises after it.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Debouncers: a new level is taken after CKS consecutive cycles
    // ------------------------------------------------------------------
    logic           req_db_q, req_db_d;
    logic [RCW-1:0] req_cnt_q, req_cnt_d;
    logic           ack_db_q, ack_db_d;
    logic [ACW-1:0] ack_cnt_q, ack_cnt_d;

    // Count how long rcv0_req has differed from its debounced level.
    always_comb begin
        req_db_d  = req_db_q;
        req_cnt_d = '0;
        if (rcv0_req != req_db_q) begin
            if (req_cnt_q == RCW'(RCV_REQ_CKS - 1)) begin
                req_db_d = rcv0_req;
            end else begin
                req_cnt_d = req_cnt_q + 1'b1;
            end
        end
    end

    // Count how long snd0_ack has differed from its debounced level.
    always_comb begin
        ack_db_d  = ack_db_q;
        ack_cnt_d = '0;
        if (snd0_ack != ack_db_q) begin
            if (ack_cnt_q == ACW'(SND_ACK_CKS - 1)) begin
                ack_db_d = snd0_ack;
            end else begin
                ack_cnt_d = ack_cnt_q + 1'b1;
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            req_db_q  <= 1'b0;
            req_cnt_q <= '0;
            ack_db_q  <= 1'b0;
            ack_cnt_q <= '0;
        end else begin
            req_db_q  <= req_db_d;
            req_cnt_q <= req_cnt_d;
            ack_db_q  <= ack_db_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Packet input and assembly
    // ------------------------------------------------------------------
    in_st_e          in_st_q, in_st_d;
    logic [IDXW-1:0] pk_idx_q, pk_idx_d;
    logic [SHW-1:0]  sh_q, sh_d;
    logic            push_q, push_d;
    logic [MSZ-1:0]  push_msg_q, push_msg_d;
    logic [PW-1:0]   shifted;
    logic [MSZ-1:0]  asm_msg;
    logic            fifo_full;
    logic            fifo_empty;
    logic [MSZ-1:0]  fifo_rdata;
    logic            pop;

`ifdef NS_PAKIN_REDUN_CHECK_EN
    logic err_q, err_d;
    logic red_ok;
`endif

    // Accept packets, shift payloads in and hand finished messages to the FIFO.
    // Packets shift in from the bottom, so after TOT_PKS shifts the header
    // packet sits at the top and older partial data has fallen out; a restart
    // therefore only needs to reset pk_idx.
    always_comb begin
        in_st_d    = in_st_q;
        pk_idx_d   = pk_idx_q;
        sh_d       = sh_q;
        push_d     = 1'b0;
        push_msg_d = push_msg_q;
        shifted    = {sh_q, rcv0_pakio[PSZ-1:0]};
        asm_msg    = shifted[PW-1 -: MSZ];
`ifdef NS_PAKIN_REDUN_CHECK_EN
        err_d      = err_q;
        red_ok     = (RSZ'(redun_sum(RedunSumW'(asm_msg[MSZ-1 -: ASZ]),
                                     RedunSumW'(asm_msg[MSZ-ASZ-1 -: ASZ]),
                                     RedunSumW'(asm_msg[RSZ +: DSZ])))
                      == asm_msg[RSZ-1:0]);
`endif
        case (in_st_q)
            InWait: begin
                if (ready_q && req_db_q) begin
                    if (rcv0_pakio[PSZ]) begin
                        sh_d     = shifted[SHW-1:0];
                        pk_idx_d = IDXW'(1);
                        in_st_d  = InAck;
                    end else if (pk_idx_q == '0) begin
                        // Stray continuation packet: acknowledge and drop.
                        in_st_d = InAck;
                    end else if (pk_idx_q == LAST_IDX) begin
`ifdef NS_PAKIN_REDUN_CHECK_EN
                        if (!red_ok) begin
                            err_d    = 1'b1;
                            pk_idx_d = '0;
                            in_st_d  = InAck;
                        end else
`endif
                        if (!fifo_full) begin
                            // ack stays high for at least a cycle, so the
                            // registered push lands before the next decision.
                            push_d     = 1'b1;
                            push_msg_d = asm_msg;
                            pk_idx_d   = '0;
                            in_st_d    = InAck;
                        end
                    end else begin
                        sh_d     = shifted[SHW-1:0];
                        pk_idx_d = pk_idx_q + IDXW'(1);
                        in_st_d  = InAck;
                    end
                end
            end
            InAck: begin
                if (!req_db_q) begin
                    in_st_d = InWait;
                end
            end
            default: in_st_d = InWait;
        endcase
        rcv0_ack = (in_st_q == InAck);
    end

    // Input-side state registers.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            in_st_q    <= InWait;
            pk_idx_q   <= '0;
            sh_q       <= '0;
            push_q     <= 1'b0;
            push_msg_q <= '0;
        end else begin
            in_st_q    <= in_st_d;
            pk_idx_q   <= pk_idx_d;
            sh_q       <= sh_d;
            push_q     <= push_d;
            push_msg_q <= push_msg_d;
        end
    end

`ifdef NS_PAKIN_REDUN_CHECK_EN
    // Sticky redundancy error flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // ------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------
    pakin_fifo #(
        .Depth (FSZ),
        .Width (MSZ)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (reset),
        .push_i  (push_q),
        .wdata_i (push_msg_q),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Message output
    // ------------------------------------------------------------------
    out_st_e        out_st_q, out_st_d;
    logic [MSZ-1:0] msg_q, msg_d;

    // Load the FIFO tail when idle and ack is low; pop once ack is seen high.
    // The entry stays in the FIFO while presented, so it counts toward full.
    always_comb begin
        out_st_d = out_st_q;
        msg_d    = msg_q;
        pop      = 1'b0;
        case (out_st_q)
            OutIdle: begin
                if (ready_q && !ack_db_q && !fifo_empty) begin
                    msg_d    = fifo_rdata;
                    out_st_d = OutReq;
                end
            end
            OutReq: begin
                if (ack_db_q) begin
                    pop      = 1'b1;
                    out_st_d = OutIdle;
                end
            end
            default: out_st_d = OutIdle;
        endcase
        snd0_req = (out_st_q == OutReq);
    end

    // Output-side state registers; msg_q only changes on a load.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            out_st_q <= OutIdle;
            msg_q    <= '0;
        end else begin
            out_st_q <= out_st_d;
            msg_q    <= msg_d;
        end
    end

    assign snd0_src = msg_q[MSZ-1 -: ASZ];
    assign snd0_dst = msg_q[MSZ-ASZ-1 -: ASZ];
    assign snd0_dat = msg_q[RSZ +: DSZ];
    assign snd0_red = msg_q[RSZ-1:0];

endmodule
